harris_ssd_min: RTL

//  Streaming Moravec/Harris corner scorer: accepts (center, target) pixel pairs for NUM_SHIFTS

---
 rtl/harris_pkg.sv | 20 ++
 rtl/harris_sq_diff.sv | 45 ++++
 rtl/harris_ssd_min.sv | 138 +++++++++++++
 3 files changed

// File: rtl/harris_pkg.sv
// Shared types and width helpers for the Harris/Moravec SSD corner scorer.
package harris_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_DRAIN,
        ST_EMIT
    } state_t;

    // Width of a counter that must hold values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // SSD width: a squared pixel difference times the window size never overflows.
    function automatic int acc_width(input int pix_w, input int win);
        return 2 * pix_w + $clog2(win);
    endfunction

endpackage

// File: rtl/harris_sq_diff.sv
// Two-stage pipe: registers |b-a| and then its square.
module harris_sq_diff #(
    parameter int PIX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               v_in,
    input  logic [PIX_W-1:0]   a,
    input  logic [PIX_W-1:0]   b,
    output logic               v_out,
    output logic [2*PIX_W-1:0] sq
);

    localparam int SQ_W = 2 * PIX_W;

    logic signed [PIX_W:0] diff;
    logic [PIX_W-1:0]      d;
    logic                  v1;

    // One extra bit keeps the difference signed so negative results do not wrap.
    assign diff = $signed({1'b0, b}) - $signed({1'b0, a});

    // Stage 1: absolute difference.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            d  <= '0;
        end else begin
            v1 <= v_in;
            d  <= diff[PIX_W] ? PIX_W'(-diff) : diff[PIX_W-1:0];
        end
    end

    // Stage 2: square of the absolute difference.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_out <= 1'b0;
            sq    <= '0;
        end else begin
            v_out <= v1;
            sq    <= SQ_W'(d) * SQ_W'(d);
        end
    end

endmodule

// File: rtl/harris_ssd_min.sv
// Windowed multi-shift SSD corner scorer: accumulates per-shift SSD,
// tracks the minimum and reports score, shift index and corner flag.
module harris_ssd_min
    import harris_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int WIN_PIXELS = 9,
    parameter int NUM_SHIFTS = 8,
    parameter int ACC_W      = acc_width(PIX_W, WIN_PIXELS),
    parameter int IDX_W      = cnt_width(NUM_SHIFTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_center,
    input  logic [PIX_W-1:0] in_target,
    input  logic [ACC_W-1:0] in_thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_score,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_corner
);

    localparam int PCW = cnt_width(WIN_PIXELS);

    state_t           state, state_nxt;
    logic [PCW-1:0]   in_pix_cnt, acc_pix_cnt;
    logic [IDX_W-1:0] in_shift_cnt, acc_shift_cnt, best_idx;
    logic [ACC_W-1:0] acc, best, thresh_q, ssd;
    logic [2*PIX_W-1:0] sq;
    logic             sq_v, accept, in_last_pix, in_last_shift, close, frame_done;

    assign in_ready      = (state == ST_ACCUM) && !rst;
    assign out_valid     = (state == ST_EMIT);
    assign accept        = in_valid & in_ready;
    assign in_last_pix   = (in_pix_cnt == PCW'(WIN_PIXELS - 1));
    assign in_last_shift = (in_shift_cnt == IDX_W'(NUM_SHIFTS - 1));
    assign close         = sq_v && (acc_pix_cnt == PCW'(WIN_PIXELS - 1));
    assign ssd           = acc + ACC_W'(sq);

    harris_sq_diff #(.PIX_W(PIX_W)) u_sq (
        .clk   (clk),
        .rst   (rst),
        .v_in  (accept),
        .a     (in_center),
        .b     (in_target),
        .v_out (sq_v),
        .sq    (sq)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_ACCUM;
        else     state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_ACCUM: if (accept && in_last_pix && in_last_shift) state_nxt = ST_DRAIN;
            ST_DRAIN: if (frame_done) state_nxt = ST_EMIT;
            ST_EMIT:  if (out_ready) state_nxt = ST_ACCUM;
            default:  state_nxt = ST_ACCUM;
        endcase
    end

    // Input framing counters; threshold captured on the first pair of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_pix_cnt   <= '0;
            in_shift_cnt <= '0;
            thresh_q     <= '0;
        end else if (accept) begin
            if (in_pix_cnt == '0 && in_shift_cnt == '0) thresh_q <= in_thresh;
            if (in_last_pix) begin
                in_pix_cnt   <= '0;
                in_shift_cnt <= in_last_shift ? '0 : in_shift_cnt + IDX_W'(1);
            end else begin
                in_pix_cnt <= in_pix_cnt + PCW'(1);
            end
        end
    end

    // Accumulate squares per shift and keep the strict minimum across shifts.
    // Framing here is counted on the pipe output, so no tags travel through the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            acc_pix_cnt   <= '0;
            acc_shift_cnt <= '0;
            best          <= '1;
            best_idx      <= '0;
            frame_done    <= 1'b0;
        end else begin
            if (sq_v) begin
                if (close) begin
                    acc         <= '0;
                    acc_pix_cnt <= '0;
                    if (acc_shift_cnt == '0 || ssd < best) begin
                        best     <= ssd;
                        best_idx <= acc_shift_cnt;
                    end
                    if (acc_shift_cnt == IDX_W'(NUM_SHIFTS - 1)) begin
                        acc_shift_cnt <= '0;
                        frame_done    <= 1'b1;
                    end else begin
                        acc_shift_cnt <= acc_shift_cnt + IDX_W'(1);
                    end
                end else begin
                    acc         <= ssd;
                    acc_pix_cnt <= acc_pix_cnt + PCW'(1);
                end
            end
            if (state == ST_DRAIN && frame_done) frame_done <= 1'b0;
            if (state == ST_EMIT && out_ready) begin
                best     <= '1;
                best_idx <= '0;
            end
        end
    end

    // Result registers, loaded once the last window has closed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_score  <= '0;
            out_idx    <= '0;
            out_corner <= 1'b0;
        end else if (state == ST_DRAIN && frame_done) begin
            out_score  <= best;
            out_idx    <= best_idx;
            out_corner <= (best > thresh_q);
        end
    end

endmodule
